// File: rtl/io_input_ctrl.sv
// io_input_ctrl
// Read controller for the memory-mapped input port block (channels 0-2).
// Each raw external word is synchronized through two flops, debounced, and
// held in a stable shadow register. MEM-stage loads are served over a
// 4-phase req/ack handshake; unmapped addresses return zero with rd_err.
// A per-channel change flag is set on every accepted stable update, cleared
// when that channel is read, and irq is the registered OR of the flags.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             synchronous active-low reset
//   raw_in0..raw_in2  asynchronous external input words
//   rd_req, rd_addr   load request (held until ack) and its address
//   rd_data           returned word, valid with rd_ack, held afterwards
//   rd_ack            one-cycle acknowledge pulse
//   rd_err            with rd_ack, marks an unmapped address
//   chg_flag          per-channel new-stable-value flags
//   irq               registered OR of chg_flag
//
// Read FSM states:
//   state    | meaning
//   IDLE     | waiting for rd_req, captures rd_addr
//   LOOKUP   | decode captured address, launch response
//   RESP     | rd_ack high for this single cycle
//   WAIT_REL | response given, waiting for rd_req to drop

`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 6
`endif

module io_input_ctrl #(
  parameter int                       DEBOUNCE_CYCLES = 16,
  parameter int                       CNT_W           = 5,
  parameter logic [`REG_ADDR_LEN-1:0] BASE_ADDR       = 6'b110000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [`DATA_LEN-1:0]     raw_in0,
  input  logic [`DATA_LEN-1:0]     raw_in1,
  input  logic [`DATA_LEN-1:0]     raw_in2,
  input  logic                     rd_req,
  input  logic [`REG_ADDR_LEN-1:0] rd_addr,
  output logic [`DATA_LEN-1:0]     rd_data,
  output logic                     rd_ack,
  output logic                     rd_err,
  output logic [2:0]               chg_flag,
  output logic                     irq
);

  localparam int DW  = `DATA_LEN;
  localparam int AW  = `REG_ADDR_LEN;
  localparam int NCH = 3;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0]    ADDR_CH0 = BASE_ADDR;
  localparam logic [AW-1:0]    ADDR_CH1 = BASE_ADDR + AW'(1);
  localparam logic [AW-1:0]    ADDR_CH2 = BASE_ADDR + AW'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    RESP     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  logic [DW-1:0]    raw    [NCH];
  logic [DW-1:0]    sync1  [NCH];
  logic [DW-1:0]    sync2  [NCH];
  logic [DW-1:0]    stable [NCH];
  logic [CNT_W-1:0] cnt    [NCH];
  logic [NCH-1:0]   upd;

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic             hit;
  logic [1:0]       sel;
  logic [DW-1:0]    sel_data;
  logic [NCH-1:0]   rd_clr;
  logic [NCH-1:0]   chg_next;

  assign raw[0] = raw_in0;
  assign raw[1] = raw_in1;
  assign raw[2] = raw_in2;

  // Debounce completes on the edge where a differing value has already
  // persisted DEBOUNCE_CYCLES-1 cycles; that edge is the DEBOUNCE_CYCLES-th.
  always_comb begin
    upd = '0;
    for (int i = 0; i < NCH; i++) begin
      upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sync1[i]  <= '0;
        sync2[i]  <= '0;
        stable[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync1[i] <= raw[i];
        sync2[i] <= sync1[i];
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Address decode on the captured address, full-width compare.
  always_comb begin
    hit      = 1'b1;
    sel      = 2'd0;
    sel_data = '0;
    if (addr_q == ADDR_CH0) begin
      sel      = 2'd0;
      sel_data = stable[0];
    end else if (addr_q == ADDR_CH1) begin
      sel      = 2'd1;
      sel_data = stable[1];
    end else if (addr_q == ADDR_CH2) begin
      sel      = 2'd2;
      sel_data = stable[2];
    end else begin
      hit = 1'b0;
    end
  end

  // A read clears its channel's flag, but a same-edge stable update sets it
  // again: the set term is OR-ed in last so it wins.
  always_comb begin
    rd_clr = '0;
    if (state == LOOKUP && hit) begin
      rd_clr = NCH'(1) << sel;
    end
    chg_next = (chg_flag & ~rd_clr) | upd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_flag <= '0;
      irq      <= 1'b0;
    end else begin
      chg_flag <= chg_next;
      irq      <= |chg_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      rd_data <= '0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr_q <= rd_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          // Issued even if rd_req dropped meanwhile; RESP then goes to IDLE.
          rd_data <= sel_data;
          rd_ack  <= 1'b1;
          rd_err  <= ~hit;
          state   <= RESP;
        end
        RESP: begin
          rd_ack <= 1'b0;
          rd_err <= 1'b0;
          state  <= rd_req ? WAIT_REL : IDLE;
        end
        WAIT_REL: begin
          if (!rd_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
module tb_io_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] raw_in0, raw_in1, raw_in2;
  logic        rd_req;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        rd_err;
  logic [2:0]  chg_flag;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Expected response {err, data}, pushed at request time, popped on ack.
  logic [32:0] exp_q [$];

  io_input_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .CNT_W          (5),
    .BASE_ADDR      (6'b110000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in0 (raw_in0),
    .raw_in1 (raw_in1),
    .raw_in2 (raw_in2),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_ack  (rd_ack),
    .rd_err  (rd_err),
    .chg_flag(chg_flag),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every ack consumes one expected response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n === 1'b1 && rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got data %h err %b expected no ack", rd_data, rd_err);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e[31:0]);
        check("rd_err", {31'd0, rd_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_d, input logic exp_e,
                         output logic [2:0] flag_at_ack, output logic irq_at_ack);
    int n;
    exp_q.push_back({exp_e, exp_d});
    rd_addr = addr;
    rd_req  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_ack && n < 10);
    flag_at_ack = chg_flag;
    irq_at_ack  = irq;
    check("rd_latency", n, 2);
    repeat (2) begin
      tick(1);
      check("wait_rel_no_ack", {31'd0, rd_ack}, 0);
    end
    rd_req  = 1'b0;
    rd_addr = '0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    logic       q;
    logic       bounce_bad;
    int         n;

    rst_n   = 1'b0;
    raw_in0 = 32'h0000_00FF;
    raw_in1 = 32'h0;
    raw_in2 = 32'h0;
    rd_req  = 1'b0;
    rd_addr = '0;

    // Reset: three cycles, outputs all zero.
    repeat (3) begin
      tick(1);
      check("rst_data", rd_data, 0);
      check("rst_ctl", {26'd0, rd_ack, rd_err, chg_flag, irq}, 0);
    end
    rst_n = 1'b1;
    tick(17);
    check("ch0_flag_before_18", {29'd0, chg_flag}, 0);
    tick(1);
    check("ch0_flag_at_18", {29'd0, chg_flag}, 3'b001);
    check("irq_at_18", {31'd0, irq}, 1);

    do_read(6'b110000, 32'h0000_00FF, 1'b0, f, q);
    check("ch0_read_clears", {29'd0, f}, 0);
    check("ch0_read_irq", {31'd0, q}, 0);

    // Clean read of channel 1.
    raw_in1 = 32'h1234_5678;
    tick(20);
    check("ch1_flag_set", {29'd0, chg_flag}, 3'b010);
    check("ch1_irq", {31'd0, irq}, 1);
    do_read(6'b110001, 32'h1234_5678, 1'b0, f, q);
    check("ch1_read_clears", {29'd0, f}, 0);

    // Unmapped reads leave flags alone.
    raw_in1 = 32'h0000_AAAA;
    tick(20);
    do_read(6'b110011, 32'h0, 1'b1, f, q);
    check("unmapped_hi_flag", {29'd0, f}, 3'b010);
    check("unmapped_hi_irq", {31'd0, q}, 1);
    do_read(6'b101111, 32'h0, 1'b1, f, q);
    check("unmapped_lo_flag", {29'd0, f}, 3'b010);
    do_read(6'b110010, 32'h0, 1'b0, f, q);
    check("ch2_read_other_flag", {29'd0, f}, 3'b010);
    do_read(6'b110001, 32'h0000_AAAA, 1'b0, f, q);
    check("ch1_second_clear", {29'd0, f}, 0);

    // Bounce rejection on channel 2.
    bounce_bad = 1'b0;
    for (int s = 0; s < 12; s++) begin
      raw_in2 = (s % 2 == 0) ? 32'h1 : 32'h0;
      repeat (5) begin
        tick(1);
        if (chg_flag[2]) bounce_bad = 1'b1;
      end
    end
    check("bounce_reject", {31'd0, bounce_bad}, 0);
    raw_in2 = 32'h1;
    tick(17);
    check("ch2_settle_before_18", {29'd0, chg_flag}, 0);
    tick(1);
    check("ch2_settle_at_18", {29'd0, chg_flag}, 3'b100);
    do_read(6'b110010, 32'h1, 1'b0, f, q);
    check("ch2_read_clears", {29'd0, f}, 0);

    // Collision: debounce completes on the LOOKUP->RESP edge.
    raw_in0 = 32'h0000_0055;
    tick(16);
    do_read(6'b110000, 32'h0000_00FF, 1'b0, f, q);
    check("collision_flag", {29'd0, f}, 3'b001);
    check("collision_irq", {31'd0, q}, 1);
    do_read(6'b110000, 32'h0000_0055, 1'b0, f, q);
    check("post_collision_clear", {29'd0, f}, 0);

    // Reset during RESP, request kept high across reset.
    exp_q.push_back({1'b0, 32'h0000_0055});
    rd_addr = 6'b110000;
    rd_req  = 1'b1;
    tick(2);
    check("pre_reset_ack", {31'd0, rd_ack}, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    tick(1);
    check("mid_reset_ack", {31'd0, rd_ack}, 0);
    check("mid_reset_data", rd_data, 0);
    check("mid_reset_flags", {28'd0, chg_flag, irq}, 0);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_ack && n < 10);
    check("post_reset_latency", n, 2);
    rd_req  = 1'b0;
    rd_addr = '0;
    tick(25);
    check("reacquire_flags", {29'd0, chg_flag}, 3'b111);
    check("reacquire_irq", {31'd0, irq}, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
- Read controller for the memory-mapped input port block at I/O addresses 6'b110000–6'b110010, i.e. input channels 0–2.
- Synchronizes and debounces the three raw external input words into stable shadow registers.
- Serves MEM-stage load requests through a 4-phase req/ack handshake and flags unmapped addresses.
- Keeps a per-channel change flag, cleared on read, and raises an interrupt while any flag is set.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a changed synchronized value must persist before it is accepted; legal range ≥2.
- CNT_W, 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BASE_ADDR, 6'b110000: address of channel 0; channels 1 and 2 are at BASE_ADDR+1 and BASE_ADDR+2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- raw_in0  input  `DATA_LEN  asynchronous external input word, channel 0.
- raw_in1  input  `DATA_LEN  asynchronous external input word, channel 1.
- raw_in2  input  `DATA_LEN  asynchronous external input word, channel 2.
- rd_req  input  1  load request from MEM stage; held high until rd_ack is seen.
- rd_addr  input  `REG_ADDR_LEN  load address; stable while rd_req is high.
- rd_data  output  `DATA_LEN  returned word; valid while rd_ack=1.
- rd_ack  output  1  one-cycle acknowledge pulse.
- rd_err  output  1  with rd_ack, marks an unmapped address.
- chg_flag  output  3  per-channel "new stable value since last read".
- irq  output  1  registered OR of chg_flag.

Behaviour:
- Reset: when rst_n=0 at a rising edge, clear everything to zero:
  - outputs rd_data, rd_ack, rd_err, chg_flag, irq;
  - synchronizer stages, stable registers and debounce counters;
  - FSM returns to IDLE, including when reset arrives mid-transaction.
- Synchronizer: two flip-flop stages per channel, full width; sync_i is the second stage.
- Debounce, per channel i, every cycle:
  - sync_i == stable_i: counter cleared to 0.
  - sync_i != stable_i and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync_i != stable_i and counter == DEBOUNCE_CYCLES-1: stable_i <= sync_i, counter <= 0, chg_flag[i] <= 1.
  - Any bounce back to stable_i clears the counter.
  - Latency from a clean raw change to stable update: 2 + DEBOUNCE_CYCLES cycles.
- Read FSM states: IDLE, LOOKUP, RESP, WAIT_REL.
  - IDLE: if rd_req=1, capture rd_addr and go to LOOKUP.
  - LOOKUP → RESP, always. On this edge:
    - rd_data <= stable value of the addressed channel; rd_ack <= 1;
    - mapped address: rd_err <= 0 and the channel's chg_flag is cleared;
    - unmapped address: rd_data <= 0, rd_err <= 1, no flag change.
  - RESP (rd_ack=1 for exactly this one cycle): rd_ack <= 0, rd_err <= 0.
    - rd_req still 1: go to WAIT_REL.
    - rd_req already 0: go to IDLE.
  - WAIT_REL: stay until rd_req=0, then go to IDLE. No new request is accepted until rd_req has been seen low.
  - rd_data holds its last value after ack.
  - Request latency: rd_req first sampled high at edge k gives rd_ack high in the cycle after edge k+1 (2 cycles).
- Simultaneous stable update and read-clear on the same channel in the same edge:
  - rd_data returns the old stable value;
  - the set wins, so chg_flag stays 1.
- rd_req dropping during LOOKUP: the response is still issued; the FSM then returns to IDLE.
- irq <= |chg_flag_next; irq is registered, so it lags the flags by zero cycles relative to the register update.
- Widths: address comparison uses the full `REG_ADDR_LEN` bits. The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Test Plan:
- Reset with DEBOUNCE_CYCLES=16, raw_in0=32'h0000_00FF, rst_n low for 3 cycles then high → all outputs 0 during reset; after release, stable0=32'hFF and chg_flag=3'b001 at cycle 18; irq=1 from the same edge.
- Clean read: with stable1=32'h1234_5678 and chg_flag[1]=1, hold rd_req=1 with rd_addr=6'b110001 → rd_ack pulses for 1 cycle, 2 cycles after request; rd_data=32'h1234_5678, rd_err=0, chg_flag[1]=0; FSM waits in WAIT_REL until rd_req drops.
- Unmapped read at rd_addr=6'b110011 → rd_ack=1, rd_err=1, rd_data=0; chg_flag unchanged.
- Bounce rejection: raw_in2 toggles 0↔32'h1 every 5 cycles for 60 cycles, then settles at 32'h1 → no stable change or chg_flag[2] set during toggling; after settling, stable2=1 and chg_flag[2]=1 exactly 18 cycles later.
- Collision: time the debounce completion on channel 0 to the same edge as LOOKUP→RESP for 6'b110000 → rd_data holds the old value; chg_flag[0] remains 1 and irq remains 1.
- Reset mid-transaction: assert rst_n=0 during RESP → rd_ack=0 on the next edge and FSM in IDLE; a new rd_req after reset is serviced with 2-cycle latency.
